// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one main-memory port between the icache and dcache.
// One transaction in flight; IDLE -> ISSUE -> WAIT -> RESP. Response reaches the
// winner L+2 cycles after its request is sampled. Build option: ARB_ROUND_ROBIN_EN.
module memory_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 128
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ic_req_valid,
  input  logic [ADDR_WIDTH-1:0] ic_req_addr,
  output logic                  ic_rsp_valid,
  output logic [LINE_WIDTH-1:0] ic_rsp_data,
  input  logic                  dc_req_valid,
  input  logic [ADDR_WIDTH-1:0] dc_req_addr,
  input  logic                  dc_req_we,
  input  logic [LINE_WIDTH-1:0] dc_req_data,
  output logic                  dc_rsp_valid,
  output logic [LINE_WIDTH-1:0] dc_rsp_data,
  output logic                  mm_req_valid,
  output logic [ADDR_WIDTH-1:0] mm_req_addr,
  output logic                  mm_req_we,
  output logic [LINE_WIDTH-1:0] mm_req_data,
  input  logic                  mm_rsp_valid,
  input  logic [LINE_WIDTH-1:0] mm_rsp_data,
  output logic                  arb_busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t                  state;
  logic                    win_dc;   // id of the requester that owns the transaction
  logic                    sel_dc;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic                    sel_we;
  logic [LINE_WIDTH-1:0]   sel_data;

`ifdef ARB_ROUND_ROBIN_EN
  // Set when the dcache should win the next tie (i.e. the icache was granted last).
  logic                    prio_dc;

  // Tie goes to whoever was not granted last; a lone requester wins outright.
  always_comb begin
    sel_dc = dc_req_valid && (!ic_req_valid || prio_dc);
  end
`else
  // Fixed priority: the dcache wins any tie; a lone icache request still wins.
  always_comb begin
    sel_dc = dc_req_valid;
  end
`endif

  // Payload of the would-be winner; icache fills carry no write data.
  always_comb begin
    sel_addr = sel_dc ? dc_req_addr : ic_req_addr;
    sel_we   = sel_dc && dc_req_we;
    sel_data = sel_dc ? dc_req_data : '0;
  end

  // Main FSM. The mm_req_* registers hold the latched request payload and the
  // winner's rsp_data register holds the captured memory line, so every output
  // is a flop and the payload/line values are zero whenever they are not live.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= IDLE;
      win_dc       <= 1'b0;
      arb_busy     <= 1'b0;
      mm_req_valid <= 1'b0;
      mm_req_addr  <= '0;
      mm_req_we    <= 1'b0;
      mm_req_data  <= '0;
      ic_rsp_valid <= 1'b0;
      ic_rsp_data  <= '0;
      dc_rsp_valid <= 1'b0;
      dc_rsp_data  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      prio_dc      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (ic_req_valid || dc_req_valid) begin
            state        <= ISSUE;
            arb_busy     <= 1'b1;
            win_dc       <= sel_dc;
            mm_req_valid <= 1'b1;
            mm_req_addr  <= sel_addr;
            mm_req_we    <= sel_we;
            mm_req_data  <= sel_data;
`ifdef ARB_ROUND_ROBIN_EN
            prio_dc      <= !sel_dc;
`endif
          end
        end
        ISSUE: begin
          state        <= WAIT;
          mm_req_valid <= 1'b0;
          mm_req_addr  <= '0;
          mm_req_we    <= 1'b0;
          mm_req_data  <= '0;
        end
        WAIT: begin
          // Writes also wait here; the returned line goes back even if ignored.
          if (mm_rsp_valid) begin
            state <= RESP;
            if (win_dc) begin
              dc_rsp_valid <= 1'b1;
              dc_rsp_data  <= mm_rsp_data;
            end else begin
              ic_rsp_valid <= 1'b1;
              ic_rsp_data  <= mm_rsp_data;
            end
          end
        end
        RESP: begin
          state        <= IDLE;
          arb_busy     <= 1'b0;
          ic_rsp_valid <= 1'b0;
          ic_rsp_data  <= '0;
          dc_rsp_valid <= 1'b0;
          dc_rsp_data  <= '0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed table, hand-written corner sequences and a random
// run, all checked every cycle against a transaction-timing reference model.
// Build with or without ARB_ROUND_ROBIN_EN to match the DUT configuration.
module tb_memory_arbiter;
  localparam int AW = 32;
  localparam int LW = 128;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          ic_req_valid;
  logic [AW-1:0] ic_req_addr;
  logic          ic_rsp_valid;
  logic [LW-1:0] ic_rsp_data;
  logic          dc_req_valid;
  logic [AW-1:0] dc_req_addr;
  logic          dc_req_we;
  logic [LW-1:0] dc_req_data;
  logic          dc_rsp_valid;
  logic [LW-1:0] dc_rsp_data;
  logic          mm_req_valid;
  logic [AW-1:0] mm_req_addr;
  logic          mm_req_we;
  logic [LW-1:0] mm_req_data;
  logic          mm_rsp_valid;
  logic [LW-1:0] mm_rsp_data;
  logic          arb_busy;

  always #5 clk = ~clk;

  memory_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clock(clk), .reset(reset),
    .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr),
    .ic_rsp_valid(ic_rsp_valid), .ic_rsp_data(ic_rsp_data),
    .dc_req_valid(dc_req_valid), .dc_req_addr(dc_req_addr),
    .dc_req_we(dc_req_we), .dc_req_data(dc_req_data),
    .dc_rsp_valid(dc_rsp_valid), .dc_rsp_data(dc_rsp_data),
    .mm_req_valid(mm_req_valid), .mm_req_addr(mm_req_addr),
    .mm_req_we(mm_req_we), .mm_req_data(mm_req_data),
    .mm_rsp_valid(mm_rsp_valid), .mm_rsp_data(mm_rsp_data),
    .arb_busy(arb_busy)
  );

  typedef struct packed {
    logic          ic_v;
    logic [LW-1:0] ic_d;
    logic          dc_v;
    logic [LW-1:0] dc_d;
    logic          mm_v;
    logic [AW-1:0] mm_a;
    logic          mm_w;
    logic [LW-1:0] mm_d;
    logic          busy;
  } obs_t;

  typedef struct {
    bit          ic_v;
    bit          dc_v;
    bit          dc_we;
    logic [AW-1:0] ic_a;
    logic [AW-1:0] dc_a;
    logic [LW-1:0] dc_d;
    int          lat;
    logic [LW-1:0] line;
    int          e_mm;
    logic [AW-1:0] e_addr;
    bit          e_we;
    logic [LW-1:0] e_data;
    int          e_ic;
    int          e_dc;
  } vec_t;

  int n_vec = 0;
  int n_mis = 0;
  int c = 0;
  int base = 0;

  // requester side
  bit            ic_pend, dc_pend, dc_w;
  logic [AW-1:0] ic_a, dc_a;
  logic [LW-1:0] dc_d;
  bit            keep_ic, keep_dc, rand_mode, spur_force;

  // memory stub
  int            stub_cnt, stub_lat;
  logic [LW-1:0] stub_line, stub_hold;

  // reference model: one transaction described by its grant cycle and latency
  bit            m_active, m_dc, m_we, m_last_dc;
  int            m_s, m_lat;
  logic [AW-1:0] m_addr;
  logic [LW-1:0] m_data, m_line;

  // observations per scenario
  int            first_mm, ic_first, dc_first, ic_cnt, dc_cnt;
  logic [AW-1:0] f_addr;
  logic          f_we;
  logic [LW-1:0] f_data;
  bit            obs_order[$];

  function automatic logic [LW-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Spec timing: grant sampled in cycle s -> mm_req in s+1, memory answers in
  // s+1+L, winner response in s+L+2, busy over s+1..s+L+2.
  function automatic obs_t model_exp();
    obs_t e;
    e = '0;
    if (m_active) begin
      if (c == m_s + 1) begin
        e.mm_v = 1'b1;
        e.mm_a = m_addr;
        e.mm_w = m_we;
        e.mm_d = m_data;
      end
      if (c >= m_s + 1 && c <= m_s + m_lat + 2) e.busy = 1'b1;
      if (c == m_s + m_lat + 2) begin
        if (m_dc) begin
          e.dc_v = 1'b1;
          e.dc_d = m_line;
        end else begin
          e.ic_v = 1'b1;
          e.ic_d = m_line;
        end
      end
    end
    return e;
  endfunction

  task automatic chk_int(input string nm, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic chk_vec(input string nm, input logic [511:0] got, input logic [511:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic new_ic();
    ic_pend = 1'b1;
    ic_a    = $urandom & 32'hFFFF_FFF0;
  endtask

  task automatic new_dc();
    dc_pend = 1'b1;
    dc_a    = $urandom & 32'hFFFF_FFF0;
    dc_w    = 1'($urandom_range(0, 1));
    dc_d    = rand_line();
  endtask

  // One clock cycle: check outputs of cycle c, run stub and requesters, drive
  // inputs for cycle c, then advance to #1 after the next rising edge.
  task automatic step(input bit do_rst);
    obs_t got, exp;
    got      = '0;
    got.ic_v = ic_rsp_valid;  got.ic_d = ic_rsp_data;
    got.dc_v = dc_rsp_valid;  got.dc_d = dc_rsp_data;
    got.mm_v = mm_req_valid;  got.mm_a = mm_req_addr;
    got.mm_w = mm_req_we;     got.mm_d = mm_req_data;
    got.busy = arb_busy;
    exp      = model_exp();
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL outputs cycle %0d: got %h expected %h", c, got, exp);
    end
    if (ic_rsp_valid === 1'b1) begin
      ic_cnt++;
      obs_order.push_back(1'b0);
      if (ic_first < 0) ic_first = c - base;
    end
    if (dc_rsp_valid === 1'b1) begin
      dc_cnt++;
      obs_order.push_back(1'b1);
      if (dc_first < 0) dc_first = c - base;
    end
    if (mm_req_valid === 1'b1 && first_mm < 0) begin
      first_mm = c - base;
      f_addr   = mm_req_addr;
      f_we     = mm_req_we;
      f_data   = mm_req_data;
    end
    // memory stub: answers stub_lat cycles after it sees mm_req_valid
    mm_rsp_valid = 1'b0;
    mm_rsp_data  = '0;
    if (stub_cnt > 0) begin
      stub_cnt--;
      if (stub_cnt == 0) begin
        mm_rsp_valid = 1'b1;
        mm_rsp_data  = stub_hold;
      end
    end
    if (mm_req_valid === 1'b1) begin
      stub_cnt  = stub_lat;
      stub_hold = stub_line;
    end
    if (!mm_rsp_valid && !(m_active && c >= m_s + 2 && c <= m_s + m_lat + 1) &&
        (spur_force || (rand_mode && $urandom_range(0, 7) == 0))) begin
      mm_rsp_valid = 1'b1;
      mm_rsp_data  = rand_line();
    end
    // retire the finished transaction; its requester drops or re-requests
    if (m_active && c > m_s + m_lat + 2) begin
      m_active = 1'b0;
      if (m_dc) begin
        dc_pend = 1'b0;
        if (keep_dc) new_dc();
      end else begin
        ic_pend = 1'b0;
        if (keep_ic) new_ic();
      end
    end
    if (rand_mode) begin
      if (!ic_pend && $urandom_range(0, 2) == 0) new_ic();
      if (!dc_pend && $urandom_range(0, 2) == 0) new_dc();
    end
    if (do_rst) begin
      ic_pend   = 1'b0;
      dc_pend   = 1'b0;
      m_active  = 1'b0;
      m_last_dc = 1'b1;
      reset     = 1'b0;
    end else if (!m_active && (ic_pend || dc_pend)) begin
      m_dc      = dc_pend && (!ic_pend || (RR ? !m_last_dc : 1'b1));
      m_last_dc = m_dc;
      m_active  = 1'b1;
      m_s       = c;
      if (rand_mode) begin
        stub_lat  = $urandom_range(1, 6);
        stub_line = rand_line();
      end
      m_lat  = stub_lat;
      m_line = stub_line;
      m_addr = m_dc ? dc_a : ic_a;
      m_we   = m_dc && dc_w;
      m_data = m_dc ? dc_d : '0;
    end
    ic_req_valid = ic_pend;
    ic_req_addr  = ic_a;
    dc_req_valid = dc_pend;
    dc_req_addr  = dc_a;
    dc_req_we    = dc_w;
    dc_req_data  = dc_d;
    @(posedge clk);
    #1;
    reset = 1'b1;
    c++;
  endtask

  task automatic begin_entry();
    step(1'b1);
    base     = c;
    first_mm = -1;
    ic_first = -1;
    dc_first = -1;
    ic_cnt   = 0;
    dc_cnt   = 0;
    obs_order.delete();
  endtask

  task automatic drain(input string nm, input int budget);
    int done;
    done = 0;
    for (int i = 0; i < budget; i++) begin
      step(1'b0);
      if (!ic_pend && !dc_pend && !m_active) begin
        done = 1;
        break;
      end
    end
    chk_int({nm, " drain"}, done, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t tbl[6];
    reset = 1'b0;
    ic_req_valid = 1'b0; ic_req_addr = '0;
    dc_req_valid = 1'b0; dc_req_addr = '0; dc_req_we = 1'b0; dc_req_data = '0;
    mm_rsp_valid = 1'b0; mm_rsp_data = '0;
    ic_pend = 0; dc_pend = 0; dc_w = 0; ic_a = '0; dc_a = '0; dc_d = '0;
    keep_ic = 0; keep_dc = 0; rand_mode = 0; spur_force = 0;
    stub_cnt = 0; stub_lat = 3; stub_line = '0; stub_hold = '0;
    m_active = 0; m_dc = 0; m_we = 0; m_last_dc = 1; m_s = 0; m_lat = 0;
    m_addr = '0; m_data = '0; m_line = '0;
    first_mm = -1; ic_first = -1; dc_first = -1; ic_cnt = 0; dc_cnt = 0;
    f_addr = '0; f_we = 0; f_data = '0;
    @(posedge clk);
    #1;
    reset = 1'b1;

    //        ic dc we  ic_addr        dc_addr        dc_data      L  line            mm  mm_addr                         mm_we             mm_data               ic_rsp         dc_rsp
    tbl[0] = '{1, 0, 0, 32'h0000_0040, 32'h0,         128'h0,      3, {16{8'hA5}},    1,  32'h0000_0040,                  1'b0,             128'h0,               5,             -1};
    tbl[1] = '{1, 1, 0, 32'h0000_0100, 32'h0000_0200, 128'h0,      3, {16{8'h5A}},    1,  RR ? 32'h100 : 32'h200,         1'b0,             128'h0,               RR ? 5 : 11,   RR ? 11 : 5};
    tbl[2] = '{0, 1, 1, 32'h0,         32'h0000_0080, 128'h1234,   3, {16{8'h77}},    1,  32'h0000_0080,                  1'b1,             128'h1234,            -1,            5};
    tbl[3] = '{0, 1, 0, 32'h0,         32'hFFFF_FFC0, 128'h0,      1, {8{16'hBEEF}},  1,  32'hFFFF_FFC0,                  1'b0,             128'h0,               -1,            3};
    tbl[4] = '{1, 0, 0, 32'h0000_0000, 32'h0,         128'h0,      7, {4{32'h0F1E2D3C}}, 1, 32'h0000_0000,                 1'b0,             128'h0,               9,             -1};
    tbl[5] = '{1, 1, 1, 32'h0000_1000, 32'h0000_2000, 128'hCAFE,   2, {16{8'hC3}},    1,  RR ? 32'h1000 : 32'h2000,       RR ? 1'b0 : 1'b1, RR ? 128'h0 : 128'hCAFE, RR ? 4 : 9, RR ? 9 : 4};

    for (int i = 0; i < 6; i++) begin
      begin_entry();
      stub_lat  = tbl[i].lat;
      stub_line = tbl[i].line;
      ic_pend   = tbl[i].ic_v;
      ic_a      = tbl[i].ic_a;
      dc_pend   = tbl[i].dc_v;
      dc_a      = tbl[i].dc_a;
      dc_w      = tbl[i].dc_we;
      dc_d      = tbl[i].dc_d;
      drain($sformatf("vec%0d", i), 80);
      chk_int($sformatf("vec%0d first mm_req cycle", i), first_mm, tbl[i].e_mm);
      chk_vec($sformatf("vec%0d mm_req addr/we/data", i), {f_addr, f_we, f_data},
              {tbl[i].e_addr, tbl[i].e_we, tbl[i].e_data});
      chk_int($sformatf("vec%0d ic_rsp cycle", i), ic_first, tbl[i].e_ic);
      chk_int($sformatf("vec%0d dc_rsp cycle", i), dc_first, tbl[i].e_dc);
    end

    // Reset during the fifth WAIT cycle; the late memory response must vanish.
    begin_entry();
    stub_lat  = 20;
    stub_line = {16{8'h3C}};
    ic_pend   = 1'b1;
    ic_a      = 32'h0000_0300;
    while (c - base < 6) step(1'b0);
    step(1'b1);
    repeat (25) step(1'b0);
    chk_int("abort rsp count", ic_cnt + dc_cnt, 0);
    chk_int("abort arb_busy", int'(arb_busy), 0);
    stub_lat = 3;

    // Spurious memory response while idle.
    begin_entry();
    spur_force = 1'b1;
    step(1'b0);
    spur_force = 1'b0;
    repeat (3) step(1'b0);
    chk_int("spurious rsp count", ic_cnt + dc_cnt, 0);
    chk_int("spurious arb_busy", int'(arb_busy), 0);

    // Both requesters held continuously for four transactions.
    begin_entry();
    stub_line = {16{8'h96}};
    keep_ic   = 1'b1;
    keep_dc   = 1'b1;
    new_ic();
    new_dc();
    for (int i = 0; i < 80 && obs_order.size() < 4; i++) step(1'b0);
    keep_ic = 1'b0;
    keep_dc = 1'b0;
    drain("continuous", 80);
    chk_int("continuous grant count", (obs_order.size() >= 4) ? 1 : 0, 1);
    for (int k = 0; k < 4; k++)
      chk_int($sformatf("continuous grant %0d is dc", k),
              (k < obs_order.size()) ? int'(obs_order[k]) : 2,
              RR ? (k % 2) : 1);

    // Random traffic with random latency and spurious responses outside WAIT.
    begin_entry();
    rand_mode = 1'b1;
    repeat (3000) step(1'b0);
    rand_mode = 1'b0;
    drain("random", 200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
